// File: rtl/operand_fetch_scoreboard_pkg.sv
// rtl/operand_fetch_scoreboard_pkg.sv - shared constants and state type for the operand fetch stage
package operand_fetch_scoreboard_pkg;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int REG_ZERO              = 0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_t;

endpackage

// File: rtl/operand_fetch_scoreboard_regfile_scoreboard.sv
// rtl/operand_fetch_scoreboard_regfile_scoreboard.sv - per-register busy bits with forwarding-aware queries
module operand_fetch_scoreboard_regfile_scoreboard
  import operand_fetch_scoreboard_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_set_en,
  input  logic [ADDRESS_WIDTH-1:0] i_set_addr,
  input  logic                     i_clr_en,
  input  logic [ADDRESS_WIDTH-1:0] i_clr_addr,
  input  logic [ADDRESS_WIDTH-1:0] i_q0_addr,
  input  logic [ADDRESS_WIDTH-1:0] i_q1_addr,
  input  logic [ADDRESS_WIDTH-1:0] i_q2_addr,
  output logic                     o_q0_busy,
  output logic                     o_q1_busy,
  output logic                     o_q2_busy
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;

  // Set is applied after clear so a same-cycle collision leaves the bit set.
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_en) w_busy_next[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_next[i_set_addr] = 1'b1;
    w_busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  // A register being written back this cycle is already resolved by forwarding.
  assign o_q0_busy = r_busy[i_q0_addr] && !(i_clr_en && (i_clr_addr == i_q0_addr));
  assign o_q1_busy = r_busy[i_q1_addr] && !(i_clr_en && (i_clr_addr == i_q1_addr));
  assign o_q2_busy = r_busy[i_q2_addr] && !(i_clr_en && (i_clr_addr == i_q2_addr));

endmodule

// File: rtl/operand_fetch_scoreboard.sv
// rtl/operand_fetch_scoreboard.sv - hazard-checked operand fetch with one-entry output stage
module operand_fetch_scoreboard
  import operand_fetch_scoreboard_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] in_rs0,
  input  logic [ADDRESS_WIDTH-1:0] in_rs1,
  input  logic [ADDRESS_WIDTH-1:0] in_rd,
  input  logic                     in_rd_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_op0,
  output logic [WIDTH-1:0]         out_op1,
  output logic [ADDRESS_WIDTH-1:0] out_rd,
  output logic                     out_rd_en,
  input  logic                     wb_valid,
  input  logic [ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [WIDTH-1:0]         wb_data,
  output logic [ADDRESS_WIDTH-1:0] rf_a0,
  output logic [ADDRESS_WIDTH-1:0] rf_a1,
  input  logic [WIDTH-1:0]         rf_rd0,
  input  logic [WIDTH-1:0]         rf_rd1,
  output logic                     rf_we,
  output logic [ADDRESS_WIDTH-1:0] rf_a2,
  output logic [WIDTH-1:0]         rf_wd
);

  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

  stage_state_t r_state;
  stage_state_t w_state_next;

  logic [WIDTH-1:0]         r_op0;
  logic [WIDTH-1:0]         r_op1;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic                     r_rd_en;

  logic [WIDTH-1:0] w_op0;
  logic [WIDTH-1:0] w_op1;
  logic             w_busy_rs0;
  logic             w_busy_rs1;
  logic             w_busy_rd;
  logic             w_hazard;
  logic             w_accept;
  logic             w_rd_en_eff;

  assign rf_a0 = in_rs0;
  assign rf_a1 = in_rs1;
  assign rf_we = wb_valid;
  assign rf_a2 = wb_addr;
  assign rf_wd = wb_data;

  assign w_rd_en_eff = in_rd_en && (in_rd != ZERO_ADDR);

  operand_fetch_scoreboard_regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .i_set_en   (w_accept && w_rd_en_eff),
    .i_set_addr (in_rd),
    .i_clr_en   (wb_valid),
    .i_clr_addr (wb_addr),
    .i_q0_addr  (in_rs0),
    .i_q1_addr  (in_rs1),
    .i_q2_addr  (in_rd),
    .o_q0_busy  (w_busy_rs0),
    .o_q1_busy  (w_busy_rs1),
    .o_q2_busy  (w_busy_rd)
  );

  assign w_hazard = w_busy_rs0 || w_busy_rs1 || (in_rd_en && w_busy_rd);
  assign in_ready = !reset && !w_hazard && ((r_state == EMPTY) || out_ready);
  assign w_accept = in_valid && in_ready;

  // Register 0 wins over forwarding, forwarding wins over the stale file value.
  always_comb begin
    w_op0 = rf_rd0;
    if (in_rs0 == ZERO_ADDR)                w_op0 = '0;
    else if (wb_valid && wb_addr == in_rs0) w_op0 = wb_data;
    w_op1 = rf_rd1;
    if (in_rs1 == ZERO_ADDR)                w_op1 = '0;
    else if (wb_valid && wb_addr == in_rs1) w_op1 = wb_data;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_next = FULL;
      FULL:    if (out_ready && !w_accept) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_op0   <= '0;
      r_op1   <= '0;
      r_rd    <= '0;
      r_rd_en <= 1'b0;
    end else if (w_accept) begin
      r_op0   <= w_op0;
      r_op1   <= w_op1;
      r_rd    <= in_rd;
      r_rd_en <= w_rd_en_eff;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_op0   = r_op0;
  assign out_op1   = r_op1;
  assign out_rd    = r_rd;
  assign out_rd_en = r_rd_en;

endmodule

// File: tb/tb_operand_fetch_scoreboard.sv
// tb/tb_operand_fetch_scoreboard.sv - directed and randomized checks against a queue-based reference model
module tb_operand_fetch_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_rd_en;
  logic [7:0] in_rs0, in_rs1, in_rd;
  logic       out_valid, out_ready, out_rd_en;
  logic [7:0] out_op0, out_op1, out_rd;
  logic       wb_valid;
  logic [7:0] wb_addr, wb_data;
  logic [7:0] rf_a0, rf_a1, rf_rd0, rf_rd1, rf_a2, rf_wd;
  logic       rf_we;

  logic [7:0] rf_mem [0:255];

  typedef struct {
    logic [7:0] op0;
    logic [7:0] op1;
    logic [7:0] rd;
    logic       rd_en;
  } bundle_t;

  bundle_t    m_q[$];
  logic [7:0] m_rf [0:255];
  bit         m_busy [0:255];
  int         checks = 0;
  int         errors = 0;
  logic       obs_rdy;

  operand_fetch_scoreboard #(.WIDTH(8), .ADDRESS_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_rd_en(in_rd_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op0(out_op0), .out_op1(out_op1), .out_rd(out_rd), .out_rd_en(out_rd_en),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_a0(rf_a0), .rf_a1(rf_a1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
    .rf_we(rf_we), .rf_a2(rf_a2), .rf_wd(rf_wd)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (rf_we && rf_a2 != 8'd0) rf_mem[rf_a2] <= rf_wd;
  assign rf_rd0 = (rf_a0 == 8'd0) ? 8'd0 : rf_mem[rf_a0];
  assign rf_rd1 = (rf_a1 == 8'd0) ? 8'd0 : rf_mem[rf_a1];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit eff_busy(input logic [7:0] r);
    return (r != 8'd0) && m_busy[r] && !(wb_valid && wb_addr == r);
  endfunction

  function automatic logic [7:0] fetch(input logic [7:0] rs);
    if (rs == 8'd0) return 8'd0;
    if (wb_valid && wb_addr == rs) return wb_data;
    return m_rf[rs];
  endfunction

  task automatic set_in(input logic v, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] d, input logic de);
    in_valid = v; in_rs0 = s0; in_rs1 = s1; in_rd = d; in_rd_en = de;
  endtask

  task automatic set_wb(input logic v, input logic [7:0] a, input logic [7:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  // One clock: check everything visible before the edge, then advance the model.
  task automatic tick();
    bit      hz, exp_rdy, acc;
    bundle_t b;
    @(negedge clock);
    hz      = eff_busy(in_rs0) || eff_busy(in_rs1) || (in_rd_en && eff_busy(in_rd));
    exp_rdy = !reset && !hz && (m_q.size() == 0 || out_ready);
    obs_rdy = in_ready;
    chk1("in_ready", in_ready, exp_rdy);
    chk8("rf_a0", rf_a0, in_rs0);
    chk8("rf_a1", rf_a1, in_rs1);
    chk1("rf_we", rf_we, wb_valid);
    if (wb_valid) begin
      chk8("rf_a2", rf_a2, wb_addr);
      chk8("rf_wd", rf_wd, wb_data);
    end
    chk1("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk8("out_op0", out_op0, m_q[0].op0);
      chk8("out_op1", out_op1, m_q[0].op1);
      chk8("out_rd", out_rd, m_q[0].rd);
      chk1("out_rd_en", out_rd_en, m_q[0].rd_en);
    end
    acc     = in_valid && exp_rdy;
    b.op0   = fetch(in_rs0);
    b.op1   = fetch(in_rs1);
    b.rd    = in_rd;
    b.rd_en = in_rd_en && (in_rd != 8'd0);
    @(posedge clock);
    if (reset) begin
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (acc) m_q.push_back(b);
      if (wb_valid) m_busy[wb_addr] = 0;
      if (acc && b.rd_en) m_busy[b.rd] = 1;
    end
    if (wb_valid && wb_addr != 8'd0) m_rf[wb_addr] = wb_data;
    #1;
  endtask

  initial begin
    int         busy_list[$];
    logic [7:0] hold_op0;
    foreach (m_rf[i]) m_rf[i] = 8'd0;
    foreach (m_busy[i]) m_busy[i] = 0;
    reset = 1'b1;
    out_ready = 1'b0;
    set_in(0, 8'd0, 8'd0, 8'd0, 0);
    set_wb(0, 8'd0, 8'd0);

    // Preload the register file through the writeback port while held in reset.
    for (int i = 1; i < 16; i++) begin
      set_wb(1, 8'(i), (i == 3) ? 8'h11 : (i == 4) ? 8'h22 : 8'($urandom));
      tick();
    end
    set_wb(0, 8'd0, 8'd0);
    tick();
    reset = 1'b0;
    chk1("rst_valid", out_valid, 1'b0);
    chk8("rst_op0", out_op0, 8'd0);
    chk8("rst_rd", out_rd, 8'd0);

    // Basic fetch.
    out_ready = 1'b1;
    set_in(1, 8'd3, 8'd4, 8'd5, 1);
    tick();
    chk1("tp1_accept", obs_rdy, 1'b1);
    set_in(0, 8'd0, 8'd0, 8'd0, 0);
    chk1("tp1_valid", out_valid, 1'b1);
    chk8("tp1_op0", out_op0, 8'h11);
    chk8("tp1_op1", out_op1, 8'h22);
    chk8("tp1_rd", out_rd, 8'd5);
    chk1("tp1_rd_en", out_rd_en, 1'b1);

    // RAW stall on r5 until its writeback forwards.
    set_in(1, 8'd5, 8'd0, 8'd0, 0);
    repeat (3) begin
      tick();
      chk1("tp2_stall", obs_rdy, 1'b0);
    end
    set_wb(1, 8'd5, 8'h7E);
    #1;
    chk1("tp2_rf_we", rf_we, 1'b1);
    chk8("tp2_rf_a2", rf_a2, 8'd5);
    chk8("tp2_rf_wd", rf_wd, 8'h7E);
    tick();
    chk1("tp2_accept", obs_rdy, 1'b1);
    set_wb(0, 8'd0, 8'd0);
    set_in(0, 8'd0, 8'd0, 8'd0, 0);
    chk8("tp2_fwd", out_op0, 8'h7E);

    // Register 0 never busies and never reads nonzero.
    set_in(1, 8'd0, 8'd0, 8'd0, 1);
    tick();
    chk1("tp3_accept", obs_rdy, 1'b1);
    tick();
    chk1("tp3_no_stall", obs_rdy, 1'b1);
    chk1("tp3_rd_en", out_rd_en, 1'b0);
    chk8("tp3_op0", out_op0, 8'd0);
    chk8("tp3_op1", out_op1, 8'd0);

    // Backpressure holds the stage, then back-to-back replacement.
    out_ready = 1'b0;
    set_in(1, 8'd1, 8'd2, 8'd8, 1);
    hold_op0 = out_op0;
    tick();
    chk1("tp4_stall", obs_rdy, 1'b0);
    chk8("tp4_held", out_op0, hold_op0);
    chk8("tp4_held_rd", out_rd, 8'd0);
    out_ready = 1'b1;
    tick();
    chk1("tp4_accept", obs_rdy, 1'b1);
    chk1("tp4_valid", out_valid, 1'b1);
    chk8("tp4_rd", out_rd, 8'd8);

    // Same-cycle clear and set on r6: set wins.
    set_in(1, 8'd0, 8'd0, 8'd6, 1);
    tick();
    set_wb(1, 8'd6, 8'h55);
    tick();
    chk1("tp5_accept", obs_rdy, 1'b1);
    set_wb(0, 8'd0, 8'd0);
    set_in(1, 8'd6, 8'd0, 8'd0, 0);
    tick();
    chk1("tp5_set_wins", obs_rdy, 1'b0);

    // Reset flushes a full stage and the scoreboard.
    out_ready = 1'b0;
    set_in(1, 8'd3, 8'd4, 8'd7, 1);
    tick();
    chk1("tp6_accept", obs_rdy, 1'b1);
    reset = 1'b1;
    set_in(0, 8'd0, 8'd0, 8'd0, 0);
    tick();
    chk1("tp6_rdy_in_reset", obs_rdy, 1'b0);
    reset = 1'b0;
    chk1("tp6_valid", out_valid, 1'b0);
    chk8("tp6_op0", out_op0, 8'd0);
    chk8("tp6_op1", out_op1, 8'd0);
    chk8("tp6_rd", out_rd, 8'd0);
    chk1("tp6_rd_en", out_rd_en, 1'b0);
    set_in(1, 8'd7, 8'd0, 8'd0, 0);
    tick();
    chk1("tp6_no_stall", obs_rdy, 1'b1);

    // Randomized traffic over a small register window to keep hazards frequent.
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_rs0    = 8'($urandom_range(0, 15));
      in_rs1    = 8'($urandom_range(0, 15));
      in_rd     = 8'($urandom_range(0, 15));
      in_rd_en  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 9) < 5);
      wb_data   = 8'($urandom);
      busy_list.delete();
      for (int r = 1; r < 16; r++) if (m_busy[r]) busy_list.push_back(r);
      if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
        wb_addr = 8'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        wb_addr = 8'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_scoreboard.md
Name: operand_fetch_scoreboard

Overview:
- Requester side of the 2-read/1-write register file: drives its read addresses, consumes its read data, and drives its write port from a writeback stream.
- Accepts instructions (two source addresses, optional destination) on a valid/ready handshake.
- Tracks in-flight destinations in a scoreboard and stalls on hazards. Forwards same-cycle writeback data.
- Presents fetched operands on a one-entry registered output stage.

Parameters:
- WIDTH, 8, data width; matches register file WIDTH.
- ADDRESS_WIDTH, 8, register address width; 2**ADDRESS_WIDTH registers; register 0 reads as zero and is never written.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_rs0, in_rs1  in  ADDRESS_WIDTH  source register addresses
- in_rd  in  ADDRESS_WIDTH  destination address
- in_rd_en  in  1  instruction will write in_rd
- out_valid  out  1  operand bundle available
- out_ready  in  1  downstream consumes bundle when out_valid && out_ready
- out_op0, out_op1  out  WIDTH  fetched operands
- out_rd  out  ADDRESS_WIDTH  registered destination
- out_rd_en  out  1  registered destination enable
- wb_valid  in  1  writeback result present; always accepted
- wb_addr  in  ADDRESS_WIDTH  writeback destination
- wb_data  in  WIDTH  writeback value
- rf_a0, rf_a1  out  ADDRESS_WIDTH  register file read addresses
- rf_rd0, rf_rd1  in  WIDTH  register file asynchronous read data
- rf_we  out  1  register file write enable
- rf_a2  out  ADDRESS_WIDTH  register file write address
- rf_wd  out  WIDTH  register file write data

Behaviour:
- Register file reads are combinational.
  - rf_a0 = in_rs0 and rf_a1 = in_rs1, always.
  - rf_we = wb_valid, rf_a2 = wb_addr, rf_wd = wb_data, combinational pass-through.
- Scoreboard: busy bit per register; busy[0] is constant 0.
- Effective busy for address r this cycle: busy[r] && !(wb_valid && wb_addr == r).
- Hazard exists if any of these is effectively busy:
  - in_rs0;
  - in_rs1;
  - in_rd, when in_rd_en = 1 (WAW).
- Output stage has states EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - in_ready = !hazard && (EMPTY || out_ready).
  - Transitions: EMPTY to FULL on accept. FULL to EMPTY on consume without accept. FULL stays FULL on consume plus accept (back-to-back, full throughput). FULL stays FULL with held outputs when out_ready = 0.
- Accept captures on the next edge:
  - out_rd = in_rd.
  - out_rd_en = in_rd_en && (in_rd != 0).
  - out_opN = 0 if rsN == 0; else wb_data if wb_valid && wb_addr == rsN; else rf_rdN.
  - Latency: one cycle from accept to out_valid.
- Scoreboard update each edge:
  - Clear busy[wb_addr] if wb_valid.
  - Set busy[in_rd] on accept with out_rd_en condition true.
  - If set and clear hit the same address in one cycle, set wins.
- Writeback to a non-busy register or to address 0: passed to the register file (which ignores address 0); scoreboard unchanged.
- Reset (synchronous):
  - All busy bits cleared; state EMPTY.
  - out_valid, out_op0, out_op1, out_rd, out_rd_en all 0.
  - In-flight bundle discarded.
  - wb_valid during reset still writes the register file.
  - in_ready is 0 while reset is asserted.
- A bundle is never dropped or duplicated.
- Output fields are stable while out_valid && !out_ready.

Decomposition:
- Shared package holds:
  - default WIDTH / ADDRESS_WIDTH constants;
  - a REG_ZERO constant (address 0);
  - a state enum: EMPTY, FULL.
- Natural sub-module: regfile_scoreboard.
  - Contains the busy vector, set/clear ports and two effective-busy query ports plus a third for rd.
  - Applies the forwarding-clear and set-wins rules.

Test Plan:
- Reset, then rf holds r3=0x11, r4=0x22. Issue rs0=3, rs1=4, rd=5, rd_en=1 with out_ready=1 -> next cycle out_valid=1, op0=0x11, op1=0x22, out_rd=5, busy[5]=1.
- With busy[5]=1, issue rs0=5 -> in_ready=0 for every cycle until wb_valid, wb_addr=5, wb_data=0x7E. Accept occurs that same cycle with op0=0x7E forwarded; rf_we=1, rf_a2=5, rf_wd=0x7E.
- Issue rs0=0, rs1=0, rd=0, rd_en=1 -> op0=op1=0, out_rd_en=0, no busy bit set, an immediately following rs0=0 issue is not stalled.
- Hold out_ready=0 with FULL, offer a second instruction -> in_ready=0, outputs held unchanged. Raise out_ready -> consume and accept in the same cycle, out_valid stays 1 with the new bundle.
- Same-cycle wb_addr=6 clear and issue rd=6 (busy[6] was 1) -> accepted, busy[6]=1 after the edge (set wins).
- Assert reset with busy[7]=1 and FULL -> next cycle out_valid=0, all outputs 0, busy[7]=0, and an issue with rs0=7 is accepted without stall.
